uart_rx_mon: RTL

Serial receive monitor and byte buffer that sits downstream of the computer's UART transmit pin (TxD) in simulation benches and FPGA debug builds. It decodes 8N1 frames into bytes and queues them in a small first-word-fall-through FIFO, so a bench or host-side logic can pop received characters with a simple read strobe. It also flags framing and overrun errors with sticky bits. It is the receiving counterpart of the `uart` sender used to drive RxD.

---
 rtl/uart_rx_mon_if.sv | 18 +
 rtl/uart_rx_mon.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mon_if.sv
// Receive-side signal bundle of uart_rx_mon: serial line in, FIFO pop strobe, FIFO head and sticky flags.
// Handshake: a byte is popped on a rising edge where rd=1 and avail=1; dout is the head whenever avail=1.
interface uart_rx_mon_if #(
    parameter int FIFO_AW = 3
);
    logic             RxD;
    logic             rd;
    logic             clr_err;
    logic [7:0]       dout;
    logic             avail;
    logic [FIFO_AW:0] count;
    logic             ferr;
    logic             oerr;
    logic             perr;

    modport master (output RxD, rd, clr_err, input dout, avail, count, ferr, oerr, perr);
    modport slave  (input RxD, rd, clr_err, output dout, avail, count, ferr, oerr, perr);
endinterface

// File: rtl/uart_rx_mon.sv
// UART receive monitor: decodes 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) from RxD into a
// first-word-fall-through byte FIFO with sticky framing/overrun/parity flags. dbg_state exposes the FSM.
module uart_rx_mon #(
    parameter int CLK_DIV = 16,
    parameter int FIFO_AW = 3
) (
    input  logic         clk,
    input  logic         reset,
    uart_rx_mon_if.slave bus,
    output logic [2:0]   dbg_state
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLK_DIV);
    localparam int NW    = FIFO_AW + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLK_DIV - 1);

    // S_IDLE encodes as 0 on dbg_state.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PAR    = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_WAITHI = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               push_q, push_d;
    logic               ferr_q, ferr_d, oerr_q, oerr_d, ferr_set;
    logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [NW-1:0]      count_q, count_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];
    logic               rxs, pop, full, wr;
`ifdef UART_RX_PARITY_EN
    logic               perr_q, perr_d, perr_set;
`endif

    assign rxs = sync2_q;

    always_comb begin
        sync1_d  = bus.RxD;
        sync2_d  = sync1_q;
        prev_d   = rxs;
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push_d   = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (prev_q && !rxs) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    cnt_d   = BIT_M1;
                    idx_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = BIT_M1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PAR: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    perr_set = (rxs != ^shift_q);
                    state_d  = S_STOP;
                    cnt_d    = BIT_M1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs) begin
                    push_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ferr_set = 1'b1;
                    state_d  = S_WAITHI;
                end
            end
            S_WAITHI: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The completed byte stays in shift_q during the push cycle, so it is written from there.
    always_comb begin
        pop     = bus.rd && (count_q != '0);
        full    = (count_q == NW'(DEPTH));
        wr      = push_q && (!full || pop);
        wp_d    = wr  ? wp_q + FIFO_AW'(1) : wp_q;
        rp_d    = pop ? rp_q + FIFO_AW'(1) : rp_q;
        count_d = count_q;
        if (wr && !pop) count_d = count_q + NW'(1);
        if (!wr && pop) count_d = count_q - NW'(1);
        mem_d = mem_q;
        if (wr) mem_d[wp_q] = shift_q;
        ferr_d = (ferr_q && !bus.clr_err) || ferr_set;
        oerr_d = (oerr_q && !bus.clr_err) || (push_q && full && !pop);
`ifdef UART_RX_PARITY_EN
        perr_d = (perr_q && !bus.clr_err) || perr_set;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) perr_q <= 1'b0;
        else       perr_q <= perr_d;
    end
    assign bus.perr = perr_q;
`else
    assign bus.perr = 1'b0;
`endif

    assign bus.dout  = mem_q[rp_q];
    assign bus.avail = (count_q != '0);
    assign bus.count = count_q;
    assign bus.ferr  = ferr_q;
    assign bus.oerr  = oerr_q;
    assign dbg_state = state_q;
endmodule
